// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-back arbiter.
// Source indices select the per-producer slot in the packed arrays used by
// rf_wb_arbiter. The round-robin pointer is typed by wb_src_e.
package rf_wb_arbiter_pkg;
  localparam int RF_DATA_W = 32;   // RegBus width
  localparam int RF_ADDR_W = 5;    // RegAddrBus width
  localparam int NUM_SRC   = 2;
  localparam int IDX_ALU   = 0;
  localparam int IDX_MEM   = 1;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;
endpackage

// File: rtl/rf_wb_slot.sv
// One-entry write-back holding slot: valid, destination, data and age bit.
// Ports:
//   clk, rst           clock, async active-high reset
//   load               capture addr_d/data_d and set valid
//   clr                drop the held write (load wins when both are set)
//   young_d            next value of the age bit; the arbiter computes it every cycle
//   valid/addr/data    held write
//   young              1 = this slot holds the newer of two pending writes
module rf_wb_slot
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic              young_d,
  input  logic [ADDR_W-1:0] addr_d,
  input  logic [DATA_W-1:0] data_d,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              young
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
      young <= 1'b0;
    end else begin
      young <= young_d;
      if (load) begin
        valid <= 1'b1;
        addr  <= addr_d;
        data  <= data_d;
      end else if (clr) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter. ALU and load results enter one-entry
// slots through valid/ready handshakes; one write per cycle leaves through a
// registered we/waddr/wdata stage. Writes to r0 are accepted and dropped.
// Same-address writes leave in arrival order; different addresses share the
// port round-robin.
// Ports:
//   clk, rst                          clock, async active-high reset
//   alu_valid/ready/addr/data         ALU write-back handshake
//   mem_valid/ready/addr/data         load write-back handshake
//   we, waddr, wdata                  regfile write port
//   busy                              a write is held in a slot or output stage
// Optional (RF_WB_BYPASS_EN defined):
//   raddr1/raddr2 -> byp1/2_hit, byp1/2_data   combinational forward of pending writes
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy
`ifdef RF_WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic              byp1_hit,
  output logic              byp2_hit,
  output logic [DATA_W-1:0] byp1_data,
  output logic [DATA_W-1:0] byp2_data
`endif
);

  logic [NUM_SRC-1:0]             in_valid, ready, ld, grant, keep;
  logic [NUM_SRC-1:0]             slot_v, slot_young, young_d;
  logic [NUM_SRC-1:0][ADDR_W-1:0] in_addr, slot_addr;
  logic [NUM_SRC-1:0][DATA_W-1:0] in_data, slot_data;
  wb_src_e                        rr_last;

  assign in_valid = {mem_valid, alu_valid};
  assign in_addr  = {mem_addr,  alu_addr};
  assign in_data  = {mem_data,  alu_data};

  // Grant depends on slot state only, keeping valid->ready free of comb paths.
  always_comb begin
    grant = '0;
    unique case (slot_v)
      2'b01: grant[IDX_ALU] = 1'b1;
      2'b10: grant[IDX_MEM] = 1'b1;
      2'b11: begin
        if (slot_addr[IDX_ALU] == slot_addr[IDX_MEM])
          grant = slot_young[IDX_ALU] ? 2'b10 : 2'b01;  // older write first
        else
          grant = (rr_last == SRC_MEM) ? 2'b01 : 2'b10;
      end
      default: grant = '0;
    endcase
  end

  assign ready = ~slot_v | grant;
  assign keep  = slot_v & ~grant;   // still held after the edge without a reload

  always_comb begin
    ld = '0;
    for (int i = 0; i < NUM_SRC; i++)
      ld[i] = in_valid[i] & ready[i] & (in_addr[i] != '0);
  end

  // Age: a new write is younger than anything that survives the edge;
  // simultaneous loads put mem ahead; a survivor whose partner drained is older.
  always_comb begin
    young_d = '0;
    if (&ld)
      young_d[IDX_ALU] = 1'b1;
    else if (ld[IDX_ALU])
      young_d[IDX_ALU] = keep[IDX_MEM];
    else if (ld[IDX_MEM])
      young_d[IDX_MEM] = keep[IDX_ALU];
    else begin
      young_d[IDX_ALU] = slot_young[IDX_ALU] & keep[IDX_ALU] & ~grant[IDX_MEM];
      young_d[IDX_MEM] = slot_young[IDX_MEM] & keep[IDX_MEM] & ~grant[IDX_ALU];
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_slot
    rf_wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load    (ld[i]),
      .clr     (grant[i]),
      .young_d (young_d[i]),
      .addr_d  (in_addr[i]),
      .data_d  (in_data[i]),
      .valid   (slot_v[i]),
      .addr    (slot_addr[i]),
      .data    (slot_data[i]),
      .young   (slot_young[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we      <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
      rr_last <= SRC_MEM;
    end else begin
      we <= |grant;
      if (|grant) begin
        waddr   <= slot_addr[grant[IDX_MEM]];
        wdata   <= slot_data[grant[IDX_MEM]];
        rr_last <= grant[IDX_MEM] ? SRC_MEM : SRC_ALU;
      end
    end
  end

  assign alu_ready = ready[IDX_ALU];
  assign mem_ready = ready[IDX_MEM];
  assign busy      = |slot_v | we;

`ifdef RF_WB_BYPASS_EN
  logic [1:0][ADDR_W-1:0] raddr;
  logic [1:0]             hit;
  logic [1:0][DATA_W-1:0] bdata;
  logic                   yng_i, old_i;

  assign raddr = {raddr2, raddr1};
  assign yng_i = slot_young[IDX_MEM];
  assign old_i = ~yng_i;

  // Later assignments win: output stage, then older slot, then younger slot.
  always_comb begin
    hit   = '0;
    bdata = '0;
    for (int p = 0; p < 2; p++) begin
      if (raddr[p] != '0) begin
        if (we && waddr == raddr[p]) begin
          hit[p] = 1'b1; bdata[p] = wdata;
        end
        if (slot_v[old_i] && slot_addr[old_i] == raddr[p]) begin
          hit[p] = 1'b1; bdata[p] = slot_data[old_i];
        end
        if (slot_v[yng_i] && slot_addr[yng_i] == raddr[p]) begin
          hit[p] = 1'b1; bdata[p] = slot_data[yng_i];
        end
      end
    end
  end

  assign byp1_hit  = hit[0];
  assign byp2_hit  = hit[1];
  assign byp1_data = bdata[0];
  assign byp2_data = bdata[1];
`endif

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter for the CPU register file's single write port. Two producers, the ALU write-back path and the load (memory) write-back path, each hand results over through a valid/ready handshake into a one-entry holding slot. The block drives the regfile `we`/`waddr`/`wdata` from a registered output stage, keeps same-register writes in program order and drops writes to register 0. It sits between the execute/memory stages and `regfile` in the `candy` top.

## Interface
- `DATA_W`, default 32: data width; matches `RegBus`.
- `ADDR_W`, default 5: register address width; matches `RegAddrBus`.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `alu_valid` / `alu_ready`  in / out  1  ALU write-back handshake.
- `alu_addr` / `alu_data`  in  `ADDR_W` / `DATA_W`  ALU destination register and data.
- `mem_valid` / `mem_ready`  in / out  1  load write-back handshake.
- `mem_addr` / `mem_data`  in  `ADDR_W` / `DATA_W`  load destination register and data.
- `we`  out  1  regfile write enable.
- `waddr`  out  `ADDR_W`  regfile write address.
- `wdata`  out  `DATA_W`  regfile write data.
- `busy`  out  1  any slot or output stage holds a write.

## Operation
- Transfer happens on a rising edge when `x_valid && x_ready`.
- Slot x loads on a transfer with `x_addr != 0`.
- A transfer with `x_addr == 0` is accepted, then discarded. No slot load, no `we`.
- `x_ready = !slot_x_valid || grant_x`. `grant` is a function of slot state only, so there is no combinational path from valid to ready.
- Age bit per slot, used to order writes:
  - A slot loaded while the other slot stays valid is marked younger.
  - A slot becomes older when the other slot drains.
  - If both slots load on the same edge, mem is older.
- Grant rules (combinational):
  - One slot valid: grant it.
  - Both valid, same address: grant the older slot.
  - Both valid, different addresses: round-robin. Grant the slot not in `rr_last`.
  - `rr_last` updates on every grant.
- Output stage, on each edge:
  - `we <= |grant`.
  - `waddr`/`wdata` take the granted slot's contents.
  - The granted slot clears, unless it reloads on the same edge.
- `busy = slot_alu_valid | slot_mem_valid | we`.
- Reset values:
  - `we`=0, `waddr`=0, `wdata`=0, `busy`=0.
  - Both slots empty, so both readys are 1 right after reset.
  - `rr_last`=mem, so ALU wins the first contention.
  - Age bits cleared.
- Reset mid-operation discards all held writes. `we` falls asynchronously.

## Timing
- Transfer at edge E, then slot valid.
- Uncontended: `we` is high in the cycle after edge E+1, and the regfile commits at edge E+2.
- `we` is high exactly one cycle per granted write. One write per cycle, back-to-back, is sustained.
- Under continuous contention each requester gets ready every other cycle.
- Worst-case extra wait for a requester: 1 cycle.

## Configuration
- `RF_WB_BYPASS_EN` defined adds the following ports:
  - `raddr1`, `raddr2`  in  `ADDR_W`.
  - `byp1_hit`, `byp2_hit`  out  1.
  - `byp1_data`, `byp2_data`  out  `DATA_W`.
- Bypass behaviour:
  - A hit occurs when `raddr` is nonzero and matches a valid slot or a `we`-high output stage.
  - Priority: younger slot, then older slot, then output stage.
  - Combinational path. Reset: hit=0, data=0.
- Undefined: these ports are absent, and consumers stall on `busy` instead.

## Structure
- Shared `define.v`: `RegBus`, `RegAddrBus`, `ZeroWord`, `WriteEnable`/`WriteDisable`, `NOPRegAddr`.
- Sub-module `rf_wb_slot` holds valid, addr, data and age, with load/clear controls. It is instantiated twice.
- Grant logic, the round-robin pointer and the output stage live in `rf_wb_arbiter`.

## Test plan
- ALU writes addr 3, data 0xDEADBEEF, at edge 0. Required: `we`=1, `waddr`=3, `wdata`=0xDEADBEEF for one cycle after edge 1, and `busy` low after edge 2.
- Both requesters hold valid with addresses 1 and 2 for 6 cycles. Required: `we` high every cycle; grants alternate ALU, mem, ALU, …; readys toggle alternately.
- Mem writes addr 7, data 0x11, at edge 0; ALU writes addr 7, data 0x22, at edge 1. Required: `waddr`=7 with 0x11, then 0x22, regardless of `rr_last`.
- ALU writes addr 0, data 0xFFFFFFFF. Required: accepted with ready=1, `we` never asserts, `busy` stays 0.
- Load both slots, then pulse `rst` mid-cycle. Required: `we`=0 immediately; after release both readys are 1, `busy`=0 and no write appears.
- With `RF_WB_BYPASS_EN`: slot mem holds addr 5, data 0xA5, and `raddr1`=5. Required: `byp1_hit`=1 and `byp1_data`=0xA5; `raddr2`=0 gives `byp2_hit`=0.
